// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin write-back arbiter (ALU vs load) for the 8 x 8-bit
//               register file write port, with a per-register pending
//               scoreboard for RAW hazard detection at issue.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 3,
    localparam int NREGS  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    // ALU write-back requester
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    // Load unit write-back requester
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    // Destination reservation from issue
    input  logic              rsv_valid,
    output logic              rsv_ready,
    input  logic [ADDR_W-1:0] rsv_addr,
    // Source hazard lookup from issue
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              hazard1,
    output logic              hazard2,
    // Register file write port
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    // Status
    output logic [NREGS-1:0]  pending,
    output logic              wb_orphan
);

    // Last requester granted; reset to LD so the ALU wins first contention.
    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LD  = 1'b1
    } rr_e;

    rr_e               rr_last_q, rr_last_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREGS-1:0]  pending_q, pending_d;
    logic              wb_orphan_q, wb_orphan_d;

    logic              alu_acc;
    logic              ld_acc;
    logic              rsv_acc;

    // Ready only looks at the competitor's valid and the round-robin pointer,
    // so neither requester sees a combinational path from its own valid.
    assign alu_ready = !ld_valid  || (rr_last_q == RR_LD);
    assign ld_ready  = !alu_valid || (rr_last_q == RR_ALU);
    assign alu_acc   = alu_valid && alu_ready;
    assign ld_acc    = ld_valid && ld_ready && !alu_acc;

    // A pending register may be re-reserved only in the cycle its write lands.
    assign rsv_ready = !pending_q[rsv_addr] || (rf_write_q && (rf_waddr_q == rsv_addr));
    assign rsv_acc   = rsv_valid && rsv_ready;

    assign hazard1   = pending_q[chk_addr1];
    assign hazard2   = pending_q[chk_addr2];

    assign rf_write  = rf_write_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign pending   = pending_q;
    assign wb_orphan = wb_orphan_q;

    // Arbitration: register the winner onto the write port, hold addr/data otherwise.
    always_comb begin
        rr_last_d  = rr_last_q;
        rf_write_d = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_acc) begin
            rr_last_d  = RR_ALU;
            rf_write_d = 1'b1;
            rf_waddr_d = alu_addr;
            rf_wdata_d = alu_data;
        end else if (ld_acc) begin
            rr_last_d  = RR_LD;
            rf_write_d = 1'b1;
            rf_waddr_d = ld_addr;
            rf_wdata_d = ld_data;
        end
    end

    // Scoreboard: clear on the storing edge, then set on reservation (set wins).
    always_comb begin
        pending_d   = pending_q;
        wb_orphan_d = wb_orphan_q;
        if (rf_write_q) begin
            pending_d[rf_waddr_q] = 1'b0;
            if (!pending_q[rf_waddr_q] && !(rsv_acc && (rsv_addr == rf_waddr_q))) begin
                wb_orphan_d = 1'b1;
            end
        end
        if (rsv_acc) begin
            pending_d[rsv_addr] = 1'b1;
        end
    end

    // State registers; reset drops any registered but unwritten write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q   <= RR_LD;
            rf_write_q  <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            pending_q   <= '0;
            wb_orphan_q <= 1'b0;
        end else begin
            rr_last_q   <= rr_last_d;
            rf_write_q  <= rf_write_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            pending_q   <= pending_d;
            wb_orphan_q <= wb_orphan_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Scoreboard bench for regfile_wb_arbiter with a behavioural
//               reference model and a simple register-file array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_valid, alu_ready, ld_valid, ld_ready, rsv_valid, rsv_ready;
    logic [2:0] alu_addr, ld_addr, rsv_addr, chk_addr1, chk_addr2, rf_waddr;
    logic [7:0] alu_data, ld_data, rf_wdata, pending;
    logic       hazard1, hazard2, rf_write, wb_orphan;

    regfile_wb_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_addr(rsv_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .hazard1(hazard1), .hazard2(hazard2),
        .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pending(pending), .wb_orphan(wb_orphan)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [2:0] a; logic [7:0] d; } wb_t;
    wb_t        exp_q[$];
    wb_t        e;
    bit         m_last_ld;          // 1: last grant was the load unit
    bit [7:0]   m_pend;
    bit         m_orph;
    bit         m_wv;               // a write-back is sitting on the port
    bit [2:0]   m_wa;
    bit [7:0]   m_wd;
    logic [7:0] m_rf [8];
    logic [7:0] tb_rf [8];

    function automatic bit model_rsv_ok(input logic [2:0] a);
        return !m_pend[a] || (m_wv && m_wa == a);
    endfunction

    initial begin
        int  w;
        bit  racc;
        for (int r = 0; r < 8; r++) m_rf[r] = 8'h00;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_last_ld = 1'b1; m_pend = '0; m_orph = 1'b0;
                m_wv = 1'b0; m_wa = '0; m_wd = '0;
                exp_q.delete();
            end else begin
                // winner: sole requester, or whoever did not win last time
                w = -1;
                if (alu_valid && ld_valid) w = m_last_ld ? 0 : 1;
                else if (alu_valid)        w = 0;
                else if (ld_valid)         w = 1;
                racc = rsv_valid && model_rsv_ok(rsv_addr);
                if (m_wv) begin
                    if (!m_pend[m_wa] && !(racc && rsv_addr == m_wa)) m_orph = 1'b1;
                    m_rf[m_wa]   = m_wd;
                    m_pend[m_wa] = 1'b0;
                end
                if (racc) m_pend[rsv_addr] = 1'b1;
                m_wv = (w >= 0);
                if (w == 0) begin m_wa = alu_addr; m_wd = alu_data; m_last_ld = 1'b0; end
                if (w == 1) begin m_wa = ld_addr;  m_wd = ld_data;  m_last_ld = 1'b1; end
                if (m_wv) exp_q.push_back('{a: m_wa, d: m_wd});
            end
        end
    end

    // Register file driven by the DUT write port (not reset).
    initial begin
        for (int r = 0; r < 8; r++) tb_rf[r] = 8'h00;
        forever begin
            @(posedge clk);
            if (rf_write === 1'b1) tb_rf[rf_waddr] = rf_wdata;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_rf_write", rf_write, 0);
                chk("rst_rf_waddr", rf_waddr, 0);
                chk("rst_rf_wdata", rf_wdata, 0);
                chk("rst_pending", pending, 0);
                chk("rst_wb_orphan", wb_orphan, 0);
                chk("rst_alu_ready", alu_ready, 1);
                chk("rst_ld_ready", ld_ready, !alu_valid);
            end else begin
                chk("alu_ready", alu_ready, !(ld_valid && !m_last_ld));
                chk("ld_ready", ld_ready, !(alu_valid && m_last_ld));
                chk("rsv_ready", rsv_ready, model_rsv_ok(rsv_addr));
                chk("hazard1", hazard1, m_pend[chk_addr1]);
                chk("hazard2", hazard2, m_pend[chk_addr2]);
                chk("pending", pending, m_pend);
                chk("wb_orphan", wb_orphan, m_orph);
                if (rf_write === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("wb_unexpected", rf_write, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_addr", rf_waddr, e.a);
                        chk("wb_data", rf_wdata, e.d);
                    end
                end else begin
                    if (exp_q.size() != 0) begin
                        chk("wb_missing", rf_write, 1);
                        exp_q.delete();
                    end
                    chk("hold_waddr", rf_waddr, m_wa);
                    chk("hold_wdata", rf_wdata, m_wd);
                end
            end
            for (int r = 0; r < 8; r++) chk($sformatf("rf_r%0d", r), tb_rf[r], m_rf[r]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; ld_valid = 1'b0; rsv_valid = 1'b0;
    endtask

    task automatic rand_inputs(input int vpct);
        alu_valid = ($urandom_range(0, 99) < vpct);
        ld_valid  = ($urandom_range(0, 99) < vpct);
        rsv_valid = ($urandom_range(0, 99) < 35);
        alu_addr  = 3'($urandom_range(0, 7));
        ld_addr   = 3'($urandom_range(0, 7));
        rsv_addr  = 3'($urandom_range(0, 7));
        chk_addr1 = 3'($urandom_range(0, 7));
        chk_addr2 = 3'($urandom_range(0, 7));
        alu_data  = 8'($urandom_range(0, 255));
        ld_data   = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] cont_exp [4];
        logic [7:0] r6_before;
        cont_exp[0] = 3'd1; cont_exp[1] = 3'd2; cont_exp[2] = 3'd1; cont_exp[3] = 3'd2;

        // Reset held with random inputs
        rst_n = 1'b0;
        rand_inputs(50);
        for (int i = 0; i < 3; i++) begin cyc(); rand_inputs(50); end
        idle();
        cyc();
        rst_n = 1'b1;

        // First write after reset
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 8'h5A;
        chk("first_alu_ready", alu_ready, 1);
        cyc(); idle();
        chk("first_rf_write", rf_write, 1);
        chk("first_rf_waddr", rf_waddr, 3);
        chk("first_rf_wdata", rf_wdata, 8'h5A);

        // Load-only grant leaves the pointer on LD so ALU wins next contention
        ld_valid = 1'b1; ld_addr = 3'd0; ld_data = 8'h00;
        cyc(); idle(); cyc();

        // Contention: strict alternation ALU, LD, ALU, LD
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 8'hA1;
        ld_valid  = 1'b1; ld_addr  = 3'd2; ld_data  = 8'hB2;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("contention_waddr%0d", i), rf_waddr, cont_exp[i]);
        end
        idle(); cyc();

        // Scoreboard: reserve r5, then ALU writes r5 = 11
        chk_addr1 = 3'd5; chk_addr2 = 3'd0;
        rsv_valid = 1'b1; rsv_addr = 3'd5;
        cyc(); rsv_valid = 1'b0;
        chk("sb_hazard_set", hazard1, 1);
        alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 8'h11;
        cyc(); idle();
        chk("sb_hazard_held", hazard1, 1);
        cyc();
        chk("sb_hazard_drop", hazard1, 0);
        chk("sb_rf_value", tb_rf[5], 8'h11);

        // WAW refusal on r4
        rsv_valid = 1'b1; rsv_addr = 3'd4;
        cyc();
        chk("waw_refused", rsv_ready, 0);
        ld_valid = 1'b1; ld_addr = 3'd4; ld_data = 8'h44;
        cyc(); ld_valid = 1'b0;
        chk("waw_accept_on_write", rsv_ready, 1);
        cyc(); rsv_valid = 1'b0;
        chk("waw_pending_kept", pending[4], 1);

        // Orphan write after a fresh reset
        #2 rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        chk("orphan_clear", wb_orphan, 0);
        ld_valid = 1'b1; ld_addr = 3'd7; ld_data = 8'hFF;
        cyc(); idle();
        cyc();
        chk("orphan_set", wb_orphan, 1);
        chk("orphan_rf_value", tb_rf[7], 8'hFF);
        for (int i = 0; i < 3; i++) cyc();
        chk("orphan_sticky", wb_orphan, 1);

        // Reset mid-flight drops the registered write to r6
        r6_before = tb_rf[6];
        alu_valid = 1'b1; alu_addr = 3'd6; alu_data = 8'h77;
        cyc(); idle();
        #2 rst_n = 1'b0;
        #1 chk("midrst_rf_write", rf_write, 0);
        cyc();
        chk("midrst_r6_kept", tb_rf[6], r6_before);
        rst_n = 1'b1;

        // Randomized traffic with one asynchronous reset pulse
        for (int i = 0; i < 400; i++) begin
            rand_inputs(i < 200 ? 60 : 90);
            cyc();
            if (i == 250) begin
                #2 rst_n = 1'b0;
                cyc(); cyc();
                rst_n = 1'b1;
            end
        end
        idle();
        for (int i = 0; i < 4; i++) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
